// File: rtl/qspi_flash_burst_reader.sv
// SPI/QSPI flash burst reader: one Fast Read (0Bh) or Quad Output Fast Read (6Bh) per request,
// streaming the received bytes over valid/ready with SCK stretched under backpressure.
module qspi_flash_burst_reader #(
    parameter int SCK_HALF     = 2,
    parameter int DUMMY_CYCLES = 8,
    parameter int MAX_BURST    = 256,
    parameter int CS_HIGH_MIN  = 4,
    parameter int LEN_W        = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    input  logic             quad,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             sck,
    output logic             cs_n,
    output logic [3:0]       io_o,
    output logic [3:0]       io_oe,
    input  logic [3:0]       io_i
);
    localparam int DIV_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, END_CS, FIN, ZERO_LEN} state_t;
    state_t state, state_nxt;

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_in_byte;
    logic [31:0]      shift_out;
    logic [7:0]       shift_in;
    logic             pending, pending_last, abort_pend, quad_q;
    logic [LEN_W-1:0] len_q, byte_cnt;

    logic       active, half_end, stall, rise, fall, abort_end, xfer, accept, byte_complete;
    logic [7:0] byte_next;

    // SCK edge qualification: a rising edge is held back while a finished byte still waits for room
    always_comb begin
        active        = state inside {CMD, ADDR, DUMMY, DATA};
        half_end      = (div_cnt == DIV_W'(SCK_HALF - 1));
        xfer          = pending && (!out_valid || out_ready);
        stall         = (state == DATA) && pending && !xfer;
        abort_end     = active && !sck && half_end && (abort || abort_pend);
        rise          = active && !sck && half_end && !abort_end && !stall;
        fall          = active && sck && half_end;
        accept        = (state == IDLE) && start && (len != '0);
        byte_complete = rise && (state == DATA) &&
                        (quad_q ? (bit_in_byte == 3'd1) : (bit_in_byte == 3'd7));
        byte_next     = quad_q ? {shift_in[3:0], io_i} : {shift_in[6:0], io_i[1]};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        cs_n      = 1'b0;
        io_o      = 4'b0000;
        io_oe     = 4'b0000;
        case (state)
            IDLE: begin
                busy = 1'b0;
                cs_n = 1'b1;
                if (start) state_nxt = (len == '0) ? ZERO_LEN : CMD;
            end
            ZERO_LEN: begin
                done      = 1'b1;
                cs_n      = 1'b1;
                state_nxt = IDLE;
            end
            CMD: begin
                io_oe = 4'b1101;
                io_o  = {2'b11, 1'b0, shift_out[31]};
                if (abort_end)                         state_nxt = END_CS;
                else if (fall && cnt == CNT_W'(7))     state_nxt = ADDR;
            end
            ADDR: begin
                io_oe = 4'b1101;
                io_o  = {2'b11, 1'b0, shift_out[31]};
                if (abort_end)                         state_nxt = END_CS;
                else if (fall && cnt == CNT_W'(23))    state_nxt = DUMMY;
            end
            DUMMY: begin
                if (!quad_q) begin
                    io_oe = 4'b1101;
                    io_o  = 4'b1100;
                end
                if (abort_end)                                       state_nxt = END_CS;
                else if (fall && cnt == CNT_W'(DUMMY_CYCLES - 1))    state_nxt = DATA;
            end
            DATA: begin
                if (!quad_q) begin
                    io_oe = 4'b1101;
                    io_o  = 4'b1100;
                end
                if (abort_end)                          state_nxt = END_CS;
                else if (fall && byte_cnt == len_q)     state_nxt = END_CS;
            end
            END_CS: begin
                cs_n = 1'b1;
                if (cnt == CNT_W'(CS_HIGH_MIN - 1)) state_nxt = FIN;
            end
            FIN: begin
                busy      = 1'b0;
                done      = 1'b1;
                cs_n      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // cnt counts SCK cycles inside CMD/ADDR/DUMMY and clk cycles inside END_CS
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt      <= '0;
            sck          <= 1'b0;
            cnt          <= '0;
            bit_in_byte  <= '0;
            shift_out    <= '0;
            shift_in     <= '0;
            pending      <= 1'b0;
            pending_last <= 1'b0;
            abort_pend   <= 1'b0;
            quad_q       <= 1'b0;
            len_q        <= '0;
            byte_cnt     <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
        end else begin
            if (!active) begin
                div_cnt <= '0;
                sck     <= 1'b0;
            end else if (half_end) begin
                if (rise) begin
                    sck     <= 1'b1;
                    div_cnt <= '0;
                end else if (fall) begin
                    sck     <= 1'b0;
                    div_cnt <= '0;
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (state_nxt != state)            cnt <= '0;
            else if (fall || state == END_CS)  cnt <= cnt + CNT_W'(1);

            if (accept) begin
                shift_out   <= {(quad ? 8'h6B : 8'h0B), addr};
                len_q       <= len;
                quad_q      <= quad;
                byte_cnt    <= '0;
                bit_in_byte <= '0;
            end else if (fall && (state == CMD || state == ADDR)) begin
                shift_out <= {shift_out[30:0], 1'b0};
            end

            if (rise && state == DATA) begin
                shift_in    <= byte_next;
                bit_in_byte <= byte_complete ? 3'd0 : bit_in_byte + 3'd1;
                if (byte_complete) byte_cnt <= byte_cnt + LEN_W'(1);
            end

            abort_pend <= active && (abort || abort_pend);

            if (abort_end) begin
                pending <= 1'b0;
            end else if (byte_complete) begin
                pending      <= 1'b1;
                pending_last <= (byte_cnt == len_q - LEN_W'(1));
            end else if (xfer) begin
                pending <= 1'b0;
            end

            if (xfer) begin
                out_data  <= shift_in;
                out_valid <= 1'b1;
                out_last  <= pending_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule
